mem_port_arbiter: RTL

Shares one unified synchronous memory port between the pipeline's instruction-fetch requester (I) and load/store requester (D). Both sides use a valid/ready request handshake. An owner FIFO records which requester issued each outstanding read, so in-order read data returns to the correct side. The block sits between the CPU core's pc/instr and mem_* ports and a single-port RAM or bus.

---
 rtl/arb_pkg.sv | 17 +
 rtl/arb_owner_fifo.sv | 68 ++++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared constants and helpers for the I/D memory port arbiter.
package arb_pkg;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Returns ceil(log2(n)), never less than 1 so it is usable as a width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner-id FIFO: one bit per outstanding read, so in-order read data is routed
// back to the requester that issued it.
module arb_owner_fifo
    import arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned       PW        = clog2(DEPTH);
    localparam logic [PW-1:0]     PTR_ONE   = PW'(1);
    localparam logic [PW:0]       CNT_ONE   = (PW + 1)'(1);
    localparam logic [PW:0]       CNT_FULL  = (PW + 1)'(DEPTH);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic [DEPTH-1:0] mem_q, mem_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        full  = (count_q == CNT_FULL);
        empty = (count_q == '0);
        head  = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and load/store (D),
// with a starvation guard for fetch and an owner FIFO for read-data routing.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MAX_OUT      = 4,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    output logic          i_ready,
    input  logic [AW-1:0] i_addr,
    output logic          i_rsp_valid,
    input  logic          d_valid,
    output logic          d_ready,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [DW-1:0] d_wdata,
    output logic          d_rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [AW-1:0] m_addr,
    output logic          m_we,
    output logic [DW-1:0] m_wdata,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          err
);

    localparam int unsigned   SW         = clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    logic          lock_q, lock_d;
    logic          lock_owner_q, lock_owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_q, err_d;

    logic owner;
    logic sel_valid;
    logic req_valid;
    logic accept;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_head;

    arb_owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .push_id (owner),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWN_I;
            starve_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            starve_q     <= starve_d;
            err_q        <= err_d;
        end
    end

    // Arbitration: a locked port keeps its owner until the memory accepts.
    always_comb begin
        if (lock_q) begin
            owner = lock_owner_q;
        end else if (i_valid && d_valid) begin
            owner = (starve_q >= STARVE_MAX) ? OWN_I : OWN_D;
        end else begin
            owner = d_valid ? OWN_D : OWN_I;
        end
        sel_valid = (owner == OWN_D) ? d_valid : i_valid;
        // A full FIFO blocks stores too; a same-cycle pop does not help.
        req_valid = sel_valid && !fifo_full && !reset;
        accept    = req_valid && m_ready;
        push      = accept && ((owner == OWN_I) || !d_we);
        pop       = m_rvalid && !fifo_empty;
    end

    always_comb begin
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        if (accept) begin
            lock_d = 1'b0;
        end else if (req_valid) begin
            lock_d       = 1'b1;
            lock_owner_d = owner;
        end

        if (i_valid && !(accept && (owner == OWN_I))) begin
            starve_d = (starve_q >= STARVE_MAX) ? STARVE_MAX : starve_q + STARVE_ONE;
        end else begin
            starve_d = '0;
        end

        err_d = err_q || (m_rvalid && fifo_empty);
    end

    always_comb begin
        m_valid     = req_valid;
        i_ready     = accept && (owner == OWN_I);
        d_ready     = accept && (owner == OWN_D);
        m_addr      = '0;
        m_we        = 1'b0;
        m_wdata     = '0;
        if (!reset) begin
            m_addr = (owner == OWN_D) ? d_addr : i_addr;
            if (owner == OWN_D) begin
                m_we    = d_we;
                m_wdata = d_wdata;
            end
        end
        i_rsp_valid = !reset && pop && (fifo_head == OWN_I);
        d_rsp_valid = !reset && pop && (fifo_head == OWN_D);
        rsp_rdata   = reset ? '0 : m_rdata;
        err         = err_q && !reset;
    end

    // The requester must hold valid and payload while the port is stalled.
    a_stall_stable : assert property (@(posedge clk) disable iff (reset)
        (m_valid && !m_ready) |=> (sel_valid && $stable(m_addr) && $stable(m_we)
                                   && $stable(m_wdata)));

endmodule
